// File: rtl/opc_mem_arbiter.sv
// opc_mem_arbiter: shares one 16-bit x 64K-word memory between two masters.
//   m0 (CPU) has priority; m1 (loader/DMA/debug) wins when m0 is idle or
//   after MAX_STARVE consecutive lost arbitrations.
// Ports:
//   clk, reset                       clock, async active-high reset
//   m0_req/rnw/addr/wdata, m0_ack    CPU request and one-cycle completion
//   m1_req/rnw/addr/wdata, m1_ack    loader request and one-cycle completion
//   rdata                            read data for the acked master
//   mem_ceb/oeb/rnw/addr/wdata       memory-side controls (ceb/oeb active low)
//   mem_rdata                        memory read data
//   busy                             high in ACCESS and ACK
//   owner                            index of the current or last granted master
module opc_mem_arbiter #(
  parameter int unsigned ACC_CYCLES = 1,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_rnw,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_rnw,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] rdata,
  output logic        mem_ceb,
  output logic        mem_oeb,
  output logic        mem_rnw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(ACC_CYCLES - 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(MAX_STARVE);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] starve, starve_d;
  logic          ceb_d, oeb_d, rnw_d, m0_ack_d, m1_ack_d, busy_d, owner_d;
  logic [15:0]   addr_d, wdata_d, rdata_d;
  logic          m1_win;

  // State and output registers; reset deselects memory immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      starve    <= '0;
      mem_ceb   <= 1'b1;
      mem_oeb   <= 1'b1;
      mem_rnw   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      starve    <= starve_d;
      mem_ceb   <= ceb_d;
      mem_oeb   <= oeb_d;
      mem_rnw   <= rnw_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rdata     <= rdata_d;
      m0_ack    <= m0_ack_d;
      m1_ack    <= m1_ack_d;
      busy      <= busy_d;
      owner     <= owner_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    starve_d = starve;
    ceb_d    = mem_ceb;
    oeb_d    = mem_oeb;
    rnw_d    = mem_rnw;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    rdata_d  = rdata;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    busy_d   = busy;
    owner_d  = owner;
    m1_win   = 1'b0;

    case (state)
      IDLE: begin
        m1_win = m1_req && (!m0_req || (starve >= STARVE_LIM));
        // Count only arbitrations m1 actually lost; anything else clears.
        if (m1_req && m0_req && !m1_win) begin
          starve_d = (starve == CNT_MAX) ? starve : CW'(starve + CW'(1));
        end else begin
          starve_d = '0;
        end
        if (m0_req || m1_req) begin
          owner_d = m1_win;
          addr_d  = m1_win ? m1_addr  : m0_addr;
          wdata_d = m1_win ? m1_wdata : m0_wdata;
          rnw_d   = m1_win ? m1_rnw   : m0_rnw;
          oeb_d   = !(m1_win ? m1_rnw : m0_rnw);
          ceb_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt == '0) begin
          if (mem_rnw) begin
            rdata_d = mem_rdata;
          end
          // Return to read direction so mem_rnw is low only inside ACCESS.
          ceb_d    = 1'b1;
          oeb_d    = 1'b1;
          rnw_d    = 1'b1;
          m0_ack_d = !owner;
          m1_ack_d = owner;
          state_d  = ACK;
        end else begin
          cnt_d = CW'(cnt - CW'(1));
        end
      end

      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_opc_mem_arbiter.sv
// Directed bench for opc_mem_arbiter: dut a runs ACC_CYCLES=1, dut b runs
// ACC_CYCLES=3; the idle one is held in reset while the other is exercised.
module tb_opc_mem_arbiter;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1, b_rst = 1'b1;
  logic        m0_req = 1'b0, m0_rnw = 1'b1, m1_req = 1'b0, m1_rnw = 1'b1;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

  logic        a_m0_ack, a_m1_ack, a_ceb, a_oeb, a_rnw, a_busy, a_owner;
  logic [15:0] a_rdata, a_addr, a_wdata, a_mrdata;
  logic        b_m0_ack, b_m1_ack, b_ceb, b_oeb, b_rnw, b_busy, b_owner;
  logic [15:0] b_rdata, b_addr, b_wdata, b_mrdata;

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic        pre_en = 1'b0, pre_sel = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  opc_mem_arbiter #(.ACC_CYCLES(1), .MAX_STARVE(4)) a_dut (
    .clk(clk), .reset(a_rst),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(a_m0_ack),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(a_m1_ack),
    .rdata(a_rdata), .mem_ceb(a_ceb), .mem_oeb(a_oeb), .mem_rnw(a_rnw),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_mrdata),
    .busy(a_busy), .owner(a_owner)
  );

  opc_mem_arbiter #(.ACC_CYCLES(3), .MAX_STARVE(4)) b_dut (
    .clk(clk), .reset(b_rst),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(b_m0_ack),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(b_m1_ack),
    .rdata(b_rdata), .mem_ceb(b_ceb), .mem_oeb(b_oeb), .mem_rnw(b_rnw),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_mrdata),
    .busy(b_busy), .owner(b_owner)
  );

  // Memory models: async read, write strobe on ceb=0/oeb=1/rnw=0, plus bench preload.
  assign a_mrdata = mem_a[a_addr];
  assign b_mrdata = mem_b[b_addr];
  always @(posedge clk) begin
    if (!a_ceb && a_oeb && !a_rnw) mem_a[a_addr] <= a_wdata;
    if (!b_ceb && b_oeb && !b_rnw) mem_b[b_addr] <= b_wdata;
    if (pre_en && !pre_sel) mem_a[pre_addr] <= pre_data;
    if (pre_en && pre_sel)  mem_b[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic sel, input logic [15:0] addr, input logic [15:0] data);
    pre_sel = sel; pre_addr = addr; pre_data = data; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Bounded wait for an ack; m: 0 = m0, 1 = m1, 2 = either. Ends on the ack negedge.
  task automatic wait_ack(input logic on_b, input int m, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (on_b) hit = (m == 0) ? b_m0_ack : (m == 1) ? b_m1_ack : (b_m0_ack | b_m1_ack);
      else      hit = (m == 0) ? a_m0_ack : (m == 1) ? a_m1_ack : (a_m0_ack | a_m1_ack);
    end
    check("ack_seen", 16'(hit), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int lows;
    int nacks;
    logic [15:0] st;
    logic exp_w [0:5];
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    @(negedge clk);
    preset(1'b0, 16'h0010, 16'hBEEF);
    preset(1'b1, 16'h0100, 16'hDEAD);

    // Reset values of dut a
    check("rst_ceb",   16'(a_ceb), 16'd1);
    check("rst_oeb",   16'(a_oeb), 16'd1);
    check("rst_rnw",   16'(a_rnw), 16'd1);
    check("rst_addr",  a_addr, 16'h0000);
    check("rst_rdata", a_rdata, 16'h0000);
    check("rst_acks",  16'({a_m0_ack, a_m1_ack, a_busy, a_owner}), 16'd0);
    a_rst = 1'b0;
    @(negedge clk);

    // m0 read of 0x0010, one access cycle
    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 16'h0010;
    @(negedge clk);
    check("t1_ceb",   16'(a_ceb), 16'd0);
    check("t1_oeb",   16'(a_oeb), 16'd0);
    check("t1_addr",  a_addr, 16'h0010);
    check("t1_busy",  16'(a_busy), 16'd1);
    check("t1_noack", 16'(a_m0_ack), 16'd0);
    @(negedge clk);
    check("t1_ack",   16'(a_m0_ack), 16'd1);
    check("t1_m1ack", 16'(a_m1_ack), 16'd0);
    check("t1_rdata", a_rdata, 16'hBEEF);
    check("t1_desel", 16'(a_ceb), 16'd1);
    m0_req = 1'b0;
    @(negedge clk);
    check("t1_ackoff", 16'(a_m0_ack), 16'd0);
    check("t1_idle",   16'(a_busy), 16'd0);

    // m1 writes 0x1234 to 0xFFFF, then m0 reads it back
    m1_req = 1'b1; m1_rnw = 1'b0; m1_addr = 16'hFFFF; m1_wdata = 16'h1234;
    @(negedge clk);
    check("t2_ceb",   16'(a_ceb), 16'd0);
    check("t2_oeb",   16'(a_oeb), 16'd1);
    check("t2_rnw",   16'(a_rnw), 16'd0);
    check("t2_owner", 16'(a_owner), 16'd1);
    check("t2_wdata", a_wdata, 16'h1234);
    @(negedge clk);
    check("t2_m1ack", 16'(a_m1_ack), 16'd1);
    check("t2_m0ack", 16'(a_m0_ack), 16'd0);
    check("t2_mem",   mem_a[16'hFFFF], 16'h1234);
    check("t2_rdkeep", a_rdata, 16'hBEEF);
    check("t2_rnwrel", 16'(a_rnw), 16'd1);
    m1_req = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 16'hFFFF;
    wait_ack(1'b0, 0, cyc);
    check("t2_lat",   16'(cyc), 16'd2);
    check("t2_rdata", a_rdata, 16'h1234);
    m0_req = 1'b0;
    @(negedge clk);

    // Starvation: both requesting continuously
    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 16'h0001;
    m1_req = 1'b1; m1_rnw = 1'b1; m1_addr = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      wait_ack(1'b0, 2, cyc);
      check($sformatf("t3_win%0d", i), 16'(a_m1_ack), 16'(exp_w[i]));
      if (i > 0) check($sformatf("t3_gap%0d", i), 16'(cyc), 16'd3);
      if (i == 4) check("t3_starve_clr", 16'(a_dut.starve), 16'd0);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_starve_idle", 16'(a_dut.starve), 16'd0);

    // m0 drops req right after grant
    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 16'h0010;
    @(negedge clk);
    check("t6_ceb", 16'(a_ceb), 16'd0);
    m0_req = 1'b0;
    @(negedge clk);
    check("t6_ack", 16'(a_m0_ack), 16'd1);
    lows = 0;
    repeat (4) begin
      @(negedge clk);
      if (!a_ceb || a_m0_ack) lows++;
    end
    check("t6_noretry", 16'(lows), 16'd0);

    // Switch to dut b (ACC_CYCLES=3)
    a_rst = 1'b1; b_rst = 1'b0;
    @(negedge clk);
    check("b_rst_ceb", 16'(b_ceb), 16'd1);

    // Three-cycle read; memory word changes mid-access, end value must be captured
    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 16'h0100;
    @(negedge clk);
    check("t4_ceb1", 16'(b_ceb), 16'd0);
    @(negedge clk);
    check("t4_ceb2", 16'(b_ceb), 16'd0);
    check("t4_noack2", 16'(b_m0_ack), 16'd0);
    pre_sel = 1'b1; pre_addr = 16'h0100; pre_data = 16'hCAFE; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    check("t4_ceb3", 16'(b_ceb), 16'd0);
    check("t4_rd_early", b_rdata, 16'h0000);
    @(negedge clk);
    check("t4_ack",   16'(b_m0_ack), 16'd1);
    check("t4_rdata", b_rdata, 16'hCAFE);
    check("t4_desel", 16'(b_ceb), 16'd1);
    m0_req = 1'b0;
    @(negedge clk);

    // Reset during the 2nd access cycle of a write
    m0_req = 1'b1; m0_rnw = 1'b0; m0_addr = 16'h0200; m0_wdata = 16'h5555;
    @(negedge clk);
    check("t5_rnw0", 16'(b_rnw), 16'd0);
    @(negedge clk);
    b_rst = 1'b1; m0_req = 1'b0;
    #1;
    check("t5_ceb",  16'(b_ceb), 16'd1);
    check("t5_rnw",  16'(b_rnw), 16'd1);
    check("t5_busy", 16'(b_busy), 16'd0);
    nacks = 0;
    repeat (3) begin
      @(negedge clk);
      if (b_m0_ack || b_m1_ack) nacks++;
    end
    b_rst = 1'b0;
    @(negedge clk);
    if (b_m0_ack || b_m1_ack) nacks++;
    check("t5_noack", 16'(nacks), 16'd0);
    st = 16'(b_dut.state);
    check("t5_state", st, 16'd0);
    m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 16'h0100;
    wait_ack(1'b1, 0, cyc);
    check("t5_lat",   16'(cyc), 16'd4);
    check("t5_rdata", b_rdata, 16'hCAFE);
    m0_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
